debug_unit: RTL

- Control and observation front end for the five-stage MIPS pipeline. It sits directly upstream of the pipeline top and drives its pc_enable and pc_reset inputs.
- Decodes single-byte commands from a UART receiver and runs the pipeline in continuous or single-step mode.
- After every stop it snapshots the pipeline debug outputs (PC, instruction, write-back data, rs data, rt data) and streams them out byte-by-byte through a UART transmitter handshake.

---
 rtl/debug_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/debug_unit.sv
// debug_unit: command front end for the five-stage MIPS pipeline.
// Decodes UART command bytes ('C' run, 'S' step, 'H' halt, 'R' reset).
// Drives the pipeline pc_enable/pc_reset inputs. After every stop it
// snapshots the pipeline debug words and streams them out MSB first.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   rx_data, rx_done       received byte and its one-cycle strobe
//   tx_done                transmitter finished the current byte
//   tx_start, tx_data      one-cycle start strobe and the byte to send
//   pc_addr_in .. reg_rt_data_in  pipeline debug words to snapshot
//   pc_enable, pc_reset    pipeline advance enable / active-high reset
//   halted_out             last continuous run stopped on HALT_INSTR
//   busy_out               block is not idle
module debug_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           UART_BITS    = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR   = DATA_WIDTH'(32'hFC00_0000),
    parameter int unsigned           RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [UART_BITS-1:0]  rx_data,
    input  logic                  rx_done,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [UART_BITS-1:0]  tx_data,
    input  logic [DATA_WIDTH-1:0] pc_addr_in,
    input  logic [DATA_WIDTH-1:0] pc_instr_in,
    input  logic [DATA_WIDTH-1:0] reg_w_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rs_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
    output logic                  pc_enable,
    output logic                  pc_reset,
    output logic                  halted_out,
    output logic                  busy_out
);

    localparam int unsigned SNAP_W    = 5 * DATA_WIDTH;
    localparam int unsigned NUM_BYTES = SNAP_W / UART_BITS;
    localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);
    localparam int unsigned RCNT_W    = $clog2(RESET_CYCLES + 1);

    localparam logic [UART_BITS-1:0] CMD_RUN   = UART_BITS'(8'h43);
    localparam logic [UART_BITS-1:0] CMD_STEP  = UART_BITS'(8'h53);
    localparam logic [UART_BITS-1:0] CMD_HALT  = UART_BITS'(8'h48);
    localparam logic [UART_BITS-1:0] CMD_RESET = UART_BITS'(8'h52);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND,
        ST_WAIT_TX,
        ST_RESET_PL
    } state_t;

    state_t              state_q, state_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic                pc_enable_q, pc_enable_d;
    logic                pc_reset_q, pc_reset_d;
    logic                halted_q, halted_d;
    logic                tx_start_q, tx_start_d;
    logic [UART_BITS-1:0] tx_data_q, tx_data_d;
    logic                busy_q, busy_d;

    logic cmd_run_c, cmd_step_c, cmd_halt_c, cmd_reset_c, halt_hit_c;

    // Command decode, qualified by the receive strobe
    always_comb begin
        cmd_run_c   = rx_done && (rx_data == CMD_RUN);
        cmd_step_c  = rx_done && (rx_data == CMD_STEP);
        cmd_halt_c  = rx_done && (rx_data == CMD_HALT);
        cmd_reset_c = rx_done && (rx_data == CMD_RESET);
        halt_hit_c  = (pc_instr_in == HALT_INSTR);
    end

    // State and output registers; reset behaves like an accepted 'R'
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET_PL;
            rst_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            snap_q      <= '0;
            pc_enable_q <= 1'b0;
            pc_reset_q  <= 1'b1;
            halted_q    <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            snap_q      <= snap_d;
            pc_enable_q <= pc_enable_d;
            pc_reset_q  <= pc_reset_d;
            halted_q    <= halted_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        snap_d      = snap_q;
        pc_enable_d = pc_enable_q;
        pc_reset_d  = pc_reset_q;
        halted_d    = halted_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            ST_IDLE: begin
                pc_enable_d = 1'b0;
                if (cmd_run_c) begin
                    state_d     = ST_RUN;
                    pc_enable_d = 1'b1;
                    halted_d    = 1'b0;
                end else if (cmd_step_c) begin
                    state_d     = ST_STEP;
                    pc_enable_d = 1'b1;
                end else if (cmd_reset_c) begin
                    state_d     = ST_RESET_PL;
                    rst_cnt_d   = '0;
                    pc_reset_d  = 1'b1;
                end
            end

            // Reset wins; otherwise HALT_INSTR or host 'H' stops the run
            ST_RUN: begin
                if (cmd_reset_c) begin
                    state_d     = ST_RESET_PL;
                    rst_cnt_d   = '0;
                    pc_enable_d = 1'b0;
                    pc_reset_d  = 1'b1;
                end else if (halt_hit_c || cmd_halt_c) begin
                    state_d     = ST_SNAP;
                    pc_enable_d = 1'b0;
                    halted_d    = halt_hit_c;
                end
            end

            ST_STEP: begin
                state_d     = ST_SNAP;
                pc_enable_d = 1'b0;
            end

            ST_SNAP: begin
                snap_d     = {pc_addr_in, pc_instr_in, reg_w_data_in,
                              reg_rs_data_in, reg_rt_data_in};
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = snap_q[SNAP_W-1 -: UART_BITS];
                state_d    = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (tx_done) begin
                    snap_d     = {snap_q[SNAP_W-UART_BITS-1:0], {UART_BITS{1'b0}}};
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (byte_cnt_q == BCNT_W'(NUM_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_RESET_PL: begin
                pc_enable_d = 1'b0;
                pc_reset_d  = 1'b1;
                if (rst_cnt_q == RCNT_W'(RESET_CYCLES - 1)) begin
                    pc_reset_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_RESET_PL;
                rst_cnt_d   = '0;
                pc_enable_d = 1'b0;
                pc_reset_d  = 1'b1;
            end
        endcase
    end

    // busy is registered from the next state so it tracks state_q exactly
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign pc_enable  = pc_enable_q;
    assign pc_reset   = pc_reset_q;
    assign halted_out = halted_q;
    assign busy_out   = busy_q;

endmodule
